// File: rtl/step_pkg.sv
// Shared half-step definitions: coil pattern table, fault codes and decoder FSM states.
// The motor driver uses the same table, so both ends agree on index order.
package step_pkg;

  localparam int IDX_W = 3;
  localparam logic [3:0] PAT_IDLE = 4'b0000;

  localparam logic [3:0] PAT_0 = 4'b0001;
  localparam logic [3:0] PAT_1 = 4'b0011;
  localparam logic [3:0] PAT_2 = 4'b0010;
  localparam logic [3:0] PAT_3 = 4'b0110;
  localparam logic [3:0] PAT_4 = 4'b0100;
  localparam logic [3:0] PAT_5 = 4'b1100;
  localparam logic [3:0] PAT_6 = 4'b1000;
  localparam logic [3:0] PAT_7 = 4'b1001;

  // Element i of the table is the pattern for half-step index i.
  localparam logic [7:0][3:0] PAT_TABLE = {PAT_7, PAT_6, PAT_5, PAT_4,
                                           PAT_3, PAT_2, PAT_1, PAT_0};

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_SKIP    = 2'b10
  } fault_code_e;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic             legal;
    logic             idle;
    logic [IDX_W-1:0] idx;
  } decode_t;

  function automatic decode_t decode_pat(input logic [3:0] pat);
    decode_t r;
    r.legal = 1'b0;
    r.idle  = (pat == PAT_IDLE);
    r.idx   = '0;
    for (int i = 0; i < 8; i++) begin
      if (pat == PAT_TABLE[i]) begin
        r.legal = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/step_phase_decoder_if.sv
// Coil-pattern input and position/status readout of the step phase decoder.
interface step_phase_decoder_if #(
  parameter int POS_W = 16
);
  logic [3:0]       phase_in;
  logic             clear;
  logic [POS_W-1:0] position;
  logic             step_pulse;
  logic             dir;
  logic             locked;
  logic             fault;
  logic [1:0]       fault_code;
  logic             stalled;

  modport master (
    output phase_in, clear,
    input  position, step_pulse, dir, locked, fault, fault_code, stalled
  );

  modport slave (
    input  phase_in, clear,
    output position, step_pulse, dir, locked, fault, fault_code, stalled
  );
endinterface

// File: rtl/step_pattern_sync.sv
// Two-flop synchroniser plus stability filter for the coil pattern; strobes accept once
// per newly stable pattern.
module step_pattern_sync #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] phase_in,
  output logic [3:0] pat,
  output logic       accept
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_q, accept_d;

  // acc_q remembers the last accepted pattern so a glitch that settles back is not re-accepted.
  always_comb begin
    cand_d   = sync2_q;
    acc_d    = acc_q;
    accept_d = 1'b0;
    if (sync2_q != cand_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CNT_W'(DEBOUNCE)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_d == CNT_W'(DEBOUNCE) && cand_d != acc_q) begin
      accept_d = 1'b1;
      acc_d    = cand_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      sync1_q  <= phase_in;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
    end
  end

  assign pat    = acc_q;
  assign accept = accept_q;

endmodule

// File: rtl/step_phase_decoder.sv
// Decodes looped-back half-step coil patterns into a signed position with direction,
// illegal/skip fault detection and stall timeout.
module step_phase_decoder
  import step_pkg::*;
#(
  parameter int POS_W     = 16,
  parameter int DEBOUNCE  = 4,
  parameter int STALL_CYC = 100000000
) (
  input logic                 clk,
  input logic                 rst,
  step_phase_decoder_if.slave bus
);

  localparam int STALL_W = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYC - 1);

  logic [3:0]       pat;
  logic             accept;
  decode_t          dec;
  logic [IDX_W-1:0] delta;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [POS_W-1:0] position_q, position_d;
  logic             dir_q, dir_d;
  logic             step_pulse_q, step_pulse_d;
  fault_code_e      fault_code_q, fault_code_d;
  logic             stalled_q, stalled_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  step_pattern_sync #(.DEBOUNCE(DEBOUNCE)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .phase_in (bus.phase_in),
    .pat      (pat),
    .accept   (accept)
  );

  assign dec   = decode_pat(pat);
  assign delta = dec.idx - last_idx_q;

  always_comb begin
    state_d      = state_q;
    last_idx_d   = last_idx_q;
    position_d   = position_q;
    dir_d        = dir_q;
    step_pulse_d = 1'b0;
    fault_code_d = fault_code_q;
    stalled_d    = stalled_q;
    stall_cnt_d  = stall_cnt_q;
    // clear wins over a simultaneous accept, which is simply dropped.
    if (bus.clear) begin
      state_d      = SYNC;
      position_d   = '0;
      fault_code_d = FC_NONE;
      stalled_d    = 1'b0;
      stall_cnt_d  = '0;
    end else begin
      case (state_q)
        SYNC: begin
          stalled_d   = 1'b0;
          stall_cnt_d = '0;
          if (accept && !dec.idle) begin
            if (dec.legal) begin
              last_idx_d = dec.idx;
              state_d    = TRACK;
            end else begin
              state_d      = FAULT;
              fault_code_d = FC_ILLEGAL;
            end
          end
        end
        TRACK: begin
          if (accept) begin
            if (dec.idle) begin
              state_d     = SYNC;
              stalled_d   = 1'b0;
              stall_cnt_d = '0;
            end else if (!dec.legal) begin
              state_d      = FAULT;
              fault_code_d = FC_ILLEGAL;
              stalled_d    = 1'b0;
            end else if (delta == 3'd1 || delta == 3'd7) begin
              position_d   = (delta == 3'd1) ? position_q + POS_W'(1) : position_q - POS_W'(1);
              dir_d        = (delta == 3'd1);
              step_pulse_d = 1'b1;
              last_idx_d   = dec.idx;
              stalled_d    = 1'b0;
              stall_cnt_d  = '0;
            end else if (delta != 3'd0) begin
              state_d      = FAULT;
              fault_code_d = FC_SKIP;
              stalled_d    = 1'b0;
            end
          end else if (stall_cnt_q == STALL_LAST) begin
            stalled_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
          end
        end
        default: begin
          stalled_d   = 1'b0;
          stall_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SYNC;
      last_idx_q   <= '0;
      position_q   <= '0;
      dir_q        <= 1'b0;
      step_pulse_q <= 1'b0;
      fault_code_q <= FC_NONE;
      stalled_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_idx_q   <= last_idx_d;
      position_q   <= position_d;
      dir_q        <= dir_d;
      step_pulse_q <= step_pulse_d;
      fault_code_q <= fault_code_d;
      stalled_q    <= stalled_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.position   = position_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.dir        = dir_q;
  assign bus.locked     = (state_q == TRACK);
  assign bus.fault      = (state_q == FAULT);
  assign bus.fault_code = fault_code_q;
  assign bus.stalled    = stalled_q;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Scoreboard bench: stimulus queues expected status events with their cycle stamp, a negedge
// monitor pops one whenever a step pulse occurs or the status outputs change.
module tb_step_phase_decoder;

  localparam int LAT = 7;  // drive just after posedge N -> registered effect seen after posedge N+7

  typedef struct packed {
    logic [15:0] pos;
    logic        dir;
    logic        locked;
    logic        fault;
    logic [1:0]  code;
    logic        stalled;
  } stat_t;

  typedef struct packed {
    int    cyc;
    stat_t s;
    logic  pulse;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  step_phase_decoder_if #(.POS_W(16)) bus ();
  step_phase_decoder_if #(.POS_W(4))  bus_w ();

  step_phase_decoder #(.POS_W(16), .DEBOUNCE(4), .STALL_CYC(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow counter instance so the max->min position wrap is reachable in a short run.
  step_phase_decoder #(.POS_W(4), .DEBOUNCE(4), .STALL_CYC(64)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  int    cyc = 0;
  int    checks = 0;
  int    fails = 0;
  bit    mon_en = 1'b0;
  stat_t prev_s = '0;
  evt_t  exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic stat_t snap();
    stat_t s;
    s.pos     = bus.position;
    s.dir     = bus.dir;
    s.locked  = bus.locked;
    s.fault   = bus.fault;
    s.code    = bus.fault_code;
    s.stalled = bus.stalled;
    return s;
  endfunction

  always @(negedge clk) begin
    stat_t cur;
    evt_t  e;
    if (mon_en) begin
      cur = snap();
      if (cur != prev_s || bus.step_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event cyc=%0d got pos=%h dir=%b lock=%b flt=%b code=%0d stl=%b pulse=%b, none expected",
                   cyc, cur.pos, cur.dir, cur.locked, cur.fault, cur.code, cur.stalled, bus.step_pulse);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.s !== cur || e.pulse !== bus.step_pulse) begin
            fails++;
            $display("FAIL event cyc=%0d got pos=%h dir=%b lock=%b flt=%b code=%0d stl=%b pulse=%b, expected cyc=%0d pos=%h dir=%b lock=%b flt=%b code=%0d stl=%b pulse=%b",
                     cyc, cur.pos, cur.dir, cur.locked, cur.fault, cur.code, cur.stalled, bus.step_pulse,
                     e.cyc, e.s.pos, e.s.dir, e.s.locked, e.s.fault, e.s.code, e.s.stalled, e.pulse);
          end else begin
            $display("event cyc=%0d pos=%h dir=%b lock=%b flt=%b code=%0d stl=%b pulse=%b ok",
                     cyc, cur.pos, cur.dir, cur.locked, cur.fault, cur.code, cur.stalled, bus.step_pulse);
          end
        end
      end
      prev_s = cur;
    end
  end

  task automatic expect_evt(input int c, input logic [15:0] pos, input logic d, input logic l,
                            input logic f, input logic [1:0] code, input logic st, input logic p);
    evt_t e;
    e.cyc       = c;
    e.s.pos     = pos;
    e.s.dir     = d;
    e.s.locked  = l;
    e.s.fault   = f;
    e.s.code    = code;
    e.s.stalled = st;
    e.pulse     = p;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic drive(input logic [3:0] p, output int t);
    @(posedge clk);
    #1;
    bus.phase_in = p;
    t = cyc;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_clear(output int t);
    @(posedge clk);
    #1;
    bus.clear = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
  endtask

  initial begin
    int t;
    int s;
    logic [3:0] wseq [9];

    bus.phase_in   = 4'b0000;
    bus.clear      = 1'b0;
    bus_w.phase_in = 4'b0000;
    bus_w.clear    = 1'b0;
    rst = 1'b1;
    hold(3);
    #1 rst = 1'b0;
    #1;
    check("reset_pos", 32'(bus.position), 32'h0);
    check("reset_flags", 32'({bus.step_pulse, bus.dir, bus.locked, bus.fault, bus.fault_code, bus.stalled}), 32'h0);
    mon_en = 1'b1;

    // Lock then three forward steps.
    drive(4'b0001, t); expect_evt(t + LAT, 16'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0); hold(10);
    drive(4'b0011, t); expect_evt(t + LAT, 16'd1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1); hold(10);
    drive(4'b0010, t); expect_evt(t + LAT, 16'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1); hold(10);
    drive(4'b0110, t); expect_evt(t + LAT, 16'd3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1); hold(10);
    pulse_clear(t);    expect_evt(t + 1,   16'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0); hold(10);

    // Index wrap 7->0 forward and 0->7 reverse.
    drive(4'b1001, t); expect_evt(t + LAT, 16'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0); hold(10);
    drive(4'b0001, t); expect_evt(t + LAT, 16'd1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1); hold(10);
    drive(4'b1001, t); expect_evt(t + LAT, 16'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1); hold(10);

    // Two-cycle glitch must not produce a step.
    drive(4'b0001, t); expect_evt(t + LAT, 16'd1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1); hold(10);
    drive(4'b0011, t); hold(1);
    drive(4'b0001, t); hold(12);
    check("glitch_pos", 32'(bus.position), 32'd1);

    // Skip by 3 faults with code 10; illegal afterwards keeps the first code.
    drive(4'b0110, t); expect_evt(t + LAT, 16'd1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0); hold(10);
    drive(4'b1111, t); hold(10);
    check("fault_code_held", 32'(bus.fault_code), 32'h2);
    pulse_clear(t);    expect_evt(t + 1,   16'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    check("clear_fault", 32'({bus.fault, bus.locked}), 32'h0);
    hold(10);

    // Stall timeout 64 cycles after the last step, cleared by the next step.
    drive(4'b0001, t); expect_evt(t + LAT, 16'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0); hold(10);
    drive(4'b0011, t); s = t + LAT;
    expect_evt(s,      16'd1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    expect_evt(s + 64, 16'd1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    hold(80);
    drive(4'b0010, t); expect_evt(t + LAT, 16'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1); hold(10);
    drive(4'b0000, t); expect_evt(t + LAT, 16'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0); hold(10);

    // Async reset while a new pattern is still being debounced.
    drive(4'b0001, t); expect_evt(t + LAT, 16'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0); hold(10);
    drive(4'b0011, t); hold(3);
    #1;
    expect_evt(cyc, 16'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_outputs", 32'({bus.position, bus.step_pulse, bus.dir, bus.locked, bus.fault, bus.fault_code, bus.stalled}), 32'h0);
    hold(2);
    #1 rst = 1'b0;
    t = cyc;
    expect_evt(t + LAT, 16'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    hold(10);

    // clear coincident with an accept drops the step.
    drive(4'b0010, t); hold(6);
    #1 bus.clear = 1'b1;
    expect_evt(t + LAT, 16'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.clear = 1'b0;
    check("clear_vs_accept_pulse", 32'(bus.step_pulse), 32'h0);
    hold(20);
    check("clear_vs_accept_pos", 32'(bus.position), 32'h0);

    // Two's complement wrap on the narrow instance: +7 then +1 -> -8.
    wseq[0] = 4'b0001; wseq[1] = 4'b0011; wseq[2] = 4'b0010; wseq[3] = 4'b0110;
    wseq[4] = 4'b0100; wseq[5] = 4'b1100; wseq[6] = 4'b1000; wseq[7] = 4'b1001;
    wseq[8] = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1 bus_w.phase_in = wseq[i];
      hold(10);
      if (i == 7) check("wrap_pos_max", 32'(bus_w.position), 32'h7);
    end
    check("wrap_pos_min", 32'(bus_w.position), 32'h8);
    check("wrap_dir", 32'(bus_w.dir), 32'h1);

    hold(10);
    while (exp_q.size() > 0) begin
      evt_t e;
      e = exp_q.pop_front();
      checks++;
      fails++;
      $display("FAIL missing_event got=none expected cyc=%0d pos=%h pulse=%b", e.cyc, e.s.pos, e.pulse);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
